// File: rtl/vga_pkg.sv
// vga_pkg: key codes, set-2 scancodes and FSM state types shared by the PS/2 decoder and drawing logic
package vga_pkg;
   localparam logic [3:0] KEY_NONE = 4'h0;
   localparam logic [3:0] key_1    = 4'h1;
   localparam logic [3:0] key_2    = 4'h2;
   localparam logic [3:0] key_3    = 4'h3;
   localparam logic [3:0] key_4    = 4'h4;
   localparam logic [3:0] key_esc  = 4'hF;
   localparam logic [7:0] SC_BREAK = 8'hF0;
   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] SC_1     = 8'h16;
   localparam logic [7:0] SC_2     = 8'h1E;
   localparam logic [7:0] SC_3     = 8'h26;
   localparam logic [7:0] SC_4     = 8'h25;
   localparam logic [7:0] SC_ESC   = 8'h76;
   typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
   typedef enum logic [1:0] {DEC_IDLE, DEC_BREAK, DEC_EXT, DEC_EXT_BREAK} dec_state_t;
   function automatic logic [3:0] map_key(input logic [7:0] sc);
      return sc == SC_1 ? key_1 : sc == SC_2 ? key_2 : sc == SC_3 ? key_3 :
             sc == SC_4 ? key_4 : sc == SC_ESC ? key_esc : KEY_NONE;
   endfunction
endpackage

// File: rtl/ps2_key_decoder_rx.sv
// ps2_rx: PS/2 pin synchronisers, falling-edge detect, 11-bit frame receiver and mid-frame timeout (parity check under PS2_PARITY_CHECK_EN)
module ps2_rx
   import vga_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 130000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] rx_byte,
   output logic       byte_rdy,
   output logic       err
);
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
   logic [1:0] csync, dsync;
   logic cprev, fall, d, par_ok, rdy_n, err_n;
   rx_state_t state, state_n;
   logic [2:0] bit_cnt, bit_cnt_n;
   logic [7:0] sh_n;
   logic [TW-1:0] tcnt, tcnt_n;
`ifdef PS2_PARITY_CHECK_EN
   logic par, par_n;
   assign par_ok = ^{rx_byte, par};
`else
   assign par_ok = 1'b1;
`endif
   assign d = dsync[1];
   assign fall = cprev & ~csync[1];
   // Two-flop synchronisers plus a delayed clock copy for edge detection; idle-high lines reset to 1
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         csync <= 2'b11;
         dsync <= 2'b11;
         cprev <= 1'b1;
      end else begin
         csync <= {csync[0], ps2_clk};
         dsync <= {dsync[0], ps2_data};
         cprev <= csync[1];
      end
   // Receiver and timeout state registers
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state    <= RX_IDLE;
         bit_cnt  <= '0;
         rx_byte  <= '0;
         tcnt     <= '0;
         byte_rdy <= 1'b0;
         err      <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
         par      <= 1'b0;
`endif
      end else begin
         state    <= state_n;
         bit_cnt  <= bit_cnt_n;
         rx_byte  <= sh_n;
         tcnt     <= tcnt_n;
         byte_rdy <= rdy_n;
         err      <= err_n;
`ifdef PS2_PARITY_CHECK_EN
         par      <= par_n;
`endif
      end
   // Frame FSM steps on each falling ps2_clk; a stalled frame times out, but an edge in the same cycle wins
   always_comb begin
      state_n   = state;
      bit_cnt_n = bit_cnt;
      sh_n      = rx_byte;
      rdy_n     = 1'b0;
      err_n     = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_n     = par;
`endif
      tcnt_n    = fall ? '0 : (state != RX_IDLE && tcnt != TMAX) ? tcnt + 1'b1 : tcnt;
      if (fall) begin
         case (state)
            RX_IDLE: if (!d) begin
               state_n   = RX_DATA;
               bit_cnt_n = '0;
            end
            RX_DATA: begin
               sh_n      = {d, rx_byte[7:1]};
               bit_cnt_n = bit_cnt + 1'b1;
               if (bit_cnt == 3'd7) state_n = RX_PARITY;
            end
            RX_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
               par_n   = d;
`endif
               state_n = RX_STOP;
            end
            default: begin
               rdy_n   = d & par_ok;
               err_n   = ~(d & par_ok);
               state_n = RX_IDLE;
            end
         endcase
      end else if (state != RX_IDLE && tcnt == TMAX) begin
         state_n   = RX_IDLE;
         bit_cnt_n = '0;
         err_n     = 1'b1;
      end
   end
endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 set-2 make/break decoder producing a held 4-bit menu key code (parity check under PS2_PARITY_CHECK_EN)
module ps2_key_decoder
   import vga_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 130000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [3:0] key,
   output logic       key_valid,
   output logic       frame_err
);
   logic [7:0] rx_byte;
   logic byte_rdy;
   logic [3:0] code, key_n;
   dec_state_t dstate, dstate_n;
   ps2_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
      .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .rx_byte(rx_byte), .byte_rdy(byte_rdy), .err(frame_err)
   );
   assign code = map_key(rx_byte);
   // Decoder state and key output; key_valid pulses only on a real change of key
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         dstate    <= DEC_IDLE;
         key       <= KEY_NONE;
         key_valid <= 1'b0;
      end else begin
         dstate    <= dstate_n;
         key       <= key_n;
         key_valid <= key_n != key;
      end
   // Prefix tracking: F0 marks a break, E0 an extended key whose codes are swallowed
   always_comb begin
      dstate_n = dstate;
      key_n    = key;
      if (byte_rdy) begin
         case (dstate)
            DEC_IDLE: begin
               if (rx_byte == SC_BREAK) dstate_n = DEC_BREAK;
               else if (rx_byte == SC_EXT) dstate_n = DEC_EXT;
               key_n = code != KEY_NONE ? code : key;
            end
            DEC_BREAK: begin
               key_n    = (code != KEY_NONE && code == key) ? KEY_NONE : key;
               dstate_n = DEC_IDLE;
            end
            DEC_EXT: dstate_n = rx_byte == SC_BREAK ? DEC_EXT_BREAK : DEC_IDLE;
            default: dstate_n = DEC_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: randomized scoreboard bench for ps2_key_decoder (honours PS2_PARITY_CHECK_EN)
module tb_ps2_key_decoder;
   localparam int TO = 300;
`ifdef PS2_PARITY_CHECK_EN
   localparam bit PCHK = 1'b1;
`else
   localparam bit PCHK = 1'b0;
`endif
   typedef struct {bit is_err; logic [3:0] k; int cyc;} exp_t;
   logic clk, rst, ps2_clk, ps2_data;
   logic [3:0] key;
   logic key_valid, frame_err;
   int checks = 0, errors = 0, cyc = 0;
   exp_t q[$];
   logic [7:0] seq[$];
   logic [3:0] mkey = 4'h0;
   logic [7:0] sc_tab[5] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h76};
   logic [3:0] kc_tab[5] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'hF};

   ps2_key_decoder #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .key(key), .key_valid(key_valid), .frame_err(frame_err)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [3:0] ref_map(input logic [7:0] b);
      for (int i = 0; i < 5; i++) if (sc_tab[i] == b) return kc_tab[i];
      return 4'h0;
   endfunction

   task automatic check_evt(input bit e);
      exp_t x;
      checks++;
      if (q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_%s: got key=%0h at cycle %0d expected no event", e ? "frame_err" : "key_valid", key, cyc);
      end else begin
         x = q.pop_front();
         if (x.is_err != e || (!e && x.k !== key) || (x.cyc >= 0 && x.cyc != cyc)) begin
            errors++;
            $display("FAIL event: got err=%0b key=%0h cycle=%0d expected err=%0b key=%0h cycle=%0d", e, key, cyc, x.is_err, x.k, x.cyc);
         end
      end
   endtask

   // Monitor: every output event must match the head of the scoreboard
   always @(negedge clk) if (!rst) begin
      if (key_valid && frame_err) chk("kv_and_err_together", 1, 0);
      if (key_valid) check_evt(0);
      if (frame_err) check_evt(1);
   end

   // Reference model: gather a complete scancode sequence, then interpret it as a whole
   task automatic apply(input logic [7:0] b, input int c);
      bit ext, brk;
      logic [3:0] m, nk;
      seq.push_back(b);
      if (b == 8'hF0 || b == 8'hE0) return;
      ext = 0; brk = 0;
      foreach (seq[i]) begin
         if (seq[i] == 8'hE0) ext = 1;
         if (seq[i] == 8'hF0) brk = 1;
      end
      seq.delete();
      m = ref_map(b);
      nk = mkey;
      if (!ext) nk = brk ? ((m != 0 && m == mkey) ? 4'h0 : mkey) : (m != 0 ? m : mkey);
      if (nk != mkey) q.push_back('{0, nk, c + 4});
      mkey = nk;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int nbits);
      logic [10:0] f;
      f = {~bad_stop, ~(^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2_data = f[i];
         repeat (4) @(negedge clk);
         ps2_clk = 0;
         if (i == 10) begin
            if (bad_stop || (PCHK && bad_par)) q.push_back('{1, 4'h0, cyc + 3});
            else apply(b, cyc);
         end
         repeat (8) @(negedge clk);
         ps2_clk = 1;
         repeat (4) @(negedge clk);
      end
      ps2_data = 1;
      repeat (4) @(negedge clk);
   endtask

   task automatic send_seq(input int kind, input logic [7:0] b);
      if (kind == 1 || kind == 2 || kind == 3) send_frame(kind == 1 ? 8'hF0 : 8'hE0, 0, 0, 11);
      if (kind == 3) send_frame(8'hF0, 0, 0, 11);
      send_frame(b, 0, 0, 11);
   endtask

   task automatic settle(input string name);
      repeat (6) @(negedge clk);
      chk({name, "_key"}, key, mkey);
      chk({name, "_drained"}, q.size(), 0);
   endtask

   initial begin
      logic [7:0] b;
      int r;
      rst = 1; ps2_clk = 1; ps2_data = 1;
      repeat (3) @(negedge clk);
      chk("reset_key", key, 0);
      chk("reset_kv", key_valid, 0);
      chk("reset_err", frame_err, 0);
      rst = 0;
      repeat (4) @(negedge clk);
      send_frame(8'h1E, 0, 0, 11);
      settle("make_1e");
      chk("make_1e_abs", key, 4'h2);
      send_seq(1, 8'h1E);
      settle("break_1e");
      send_frame(8'h1E, 0, 0, 11);
      send_seq(1, 8'h26);
      settle("break_other");
      chk("break_other_abs", key, 4'h2);
      send_frame(8'h76, 0, 0, 11);
      send_frame(8'h76, 1, 0, 11);
      settle("parity");
      chk("parity_abs", key, 4'hF);
      send_frame(8'h1E, 0, 1, 11);
      settle("bad_stop");
      send_frame(8'h00, 0, 0, 5);
      q.push_back('{1, 4'h0, -1});
      repeat (TO + 40) @(negedge clk);
      chk("timeout_err", q.size(), 0);
      send_frame(8'h25, 0, 0, 11);
      settle("recover");
      chk("recover_abs", key, 4'h4);
      send_seq(2, 8'h76);
      send_seq(3, 8'h76);
      settle("ext");
      repeat (3) send_frame(8'h16, 0, 0, 11);
      settle("typematic");
      chk("typematic_abs", key, 4'h1);
      send_frame(8'h26, 0, 0, 11);
      send_frame(8'h00, 0, 0, 4);
      @(posedge clk);
      #2 rst = 1;
      #1 chk("async_reset_key", key, 0);
      mkey = 0; seq.delete();
      ps2_clk = 1; ps2_data = 1;
      repeat (3) @(negedge clk);
      rst = 0;
      repeat (4) @(negedge clk);
      send_frame(8'h26, 0, 0, 11);
      settle("after_reset");
      chk("after_reset_abs", key, 4'h3);
      for (int n = 0; n < 50; n++) begin
         r = $urandom_range(0, 9);
         if (r < 5) b = sc_tab[r];
         else begin
            b = 8'(($urandom_range(0, 255)));
            while (b == 8'hF0 || b == 8'hE0) b = 8'($urandom_range(0, 255));
         end
         r = $urandom_range(0, 5);
         if (r < 4) send_seq(r, b);
         else send_frame(b, r == 5, r == 4, 11);
         repeat ($urandom_range(0, 10)) @(negedge clk);
         settle("random");
      end
      repeat (20) @(negedge clk);
      chk("final_queue", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
